// File: rtl/vga_timing_pkg.sv
// Shared timing constants, totals helpers and command-FSM encoding for the VGA raster path.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam logic SYNC_ACTIVE_LOW = 1'b0;

  typedef enum logic {CmdIdle, CmdPend} cmd_state_e;

  function automatic int unsigned h_total(int unsigned act, int unsigned fp, int unsigned sync,
                                          int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(int unsigned act, int unsigned fp, int unsigned sync,
                                          int unsigned bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel clock-enable divider: registered strobe, high while the count sits at PIX_DIV-1.
module vga_pixel_tick #(
  parameter int unsigned PIX_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic pixel_tick
);

  localparam logic [3:0] Last = 4'(PIX_DIV - 1);

  logic [3:0] cnt_q, cnt_d;
  logic       tick_q;

  always_comb begin
    cnt_d = (cnt_q == Last) ? 4'd0 : cnt_q + 4'd1;
  end

  // Strobe is registered from the next count so it stays low throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 4'd0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == Last);
    end
  end

  assign pixel_tick = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480 raster timing generator with vblank-aligned redraw command retiming.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned PIX_DIV  = 1,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_POL = SYNC_ACTIVE_LOW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_req,
  input  logic       change_busy,
  output logic       pixel_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       h_sync,
  output logic       v_sync,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start,
  output logic       change_command,
  output logic       cmd_pending
);

  localparam int unsigned HTot = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTot = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [9:0] HLast    = 10'(HTot - 1);
  localparam logic [9:0] VLast    = 10'(VTot - 1);
  localparam logic [9:0] HAct     = 10'(H_ACTIVE);
  localparam logic [9:0] VAct     = 10'(V_ACTIVE);
  localparam logic [9:0] VActLast = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HSyncBeg = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncEnd = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VSyncBeg = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncEnd = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       tick;
  logic [9:0] x_q, y_q, x_d, y_d;
  logic       hs_q, vs_q, von_q, ls_q, fs_q;
  logic       x_last, y_last, vblank;
  cmd_state_e state_q;
  logic       cc_q, cp_q;

  vga_pixel_tick #(
    .PIX_DIV (PIX_DIV)
  ) u_pixel_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixel_tick (tick)
  );

  always_comb begin
    x_last = (x_q == HLast);
    y_last = (y_q == VLast);
    x_d    = x_last ? 10'd0 : x_q + 10'd1;
    y_d    = y_q;
    if (x_last) y_d = y_last ? 10'd0 : y_q + 10'd1;
    // The tick whose advance lands on (0, V_ACTIVE).
    vblank = tick && x_last && (y_q == VActLast);
  end

  // Decodes are computed from the next counter values so they stay aligned with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= 10'd0;
      y_q   <= 10'd0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      von_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      if (tick) begin
        x_q   <= x_d;
        y_q   <= y_d;
        hs_q  <= (x_d >= HSyncBeg && x_d < HSyncEnd) ? SYNC_POL : ~SYNC_POL;
        vs_q  <= (y_d >= VSyncBeg && y_d < VSyncEnd) ? SYNC_POL : ~SYNC_POL;
        von_q <= (x_d < HAct) && (y_d < VAct);
        ls_q  <= x_last;
        fs_q  <= x_last && y_last;
      end
    end
  end

  // Requests coalesce; a busy handler defers the issue to the next frame's vblank edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CmdIdle;
      cc_q    <= 1'b0;
      cp_q    <= 1'b0;
    end else begin
      cc_q <= 1'b0;
      unique case (state_q)
        CmdIdle: begin
          if (cmd_req) begin
            if (vblank && !change_busy) begin
              cc_q <= 1'b1;
            end else begin
              state_q <= CmdPend;
              cp_q    <= 1'b1;
            end
          end
        end
        CmdPend: begin
          if (vblank && !change_busy) begin
            cc_q    <= 1'b1;
            cp_q    <= 1'b0;
            state_q <= CmdIdle;
          end
        end
        default: begin
          state_q <= CmdIdle;
          cp_q    <= 1'b0;
        end
      endcase
    end
  end

  assign pixel_tick     = tick;
  assign pixel_x        = x_q;
  assign pixel_y        = y_q;
  assign h_sync         = hs_q;
  assign v_sync         = vs_q;
  assign video_on       = von_q;
  assign line_start     = ls_q;
  assign frame_start    = fs_q;
  assign change_command = cc_q;
  assign cmd_pending    = cp_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for the 640x480 display path; sits directly upstream of the RAM-to-screen handler.
- Produces h_sync, v_sync, video_on, pixel_x and pixel_y for that handler.
- Also retimes asynchronous redraw requests from the command parser into a single change_command pulse at the start of vertical blanking, so RAM rewrites never tear a visible frame.

Parameters:
- PIX_DIV, 1: clk cycles per pixel; pixel_tick asserts every PIX_DIV clk. Legal range 1..15.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_POL, 0: sync active level; 0 = active-low.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cmd_req  in  1  redraw request from parser; level or pulse, sampled every clk.
- change_busy  in  1  handler is currently rewriting its RAMs.
- pixel_tick  out  1  one-clk strobe marking each pixel advance.
- pixel_x  out  10  horizontal count, 0..H_TOTAL-1.
- pixel_y  out  10  vertical count, 0..V_TOTAL-1.
- h_sync  out  1  horizontal sync.
- v_sync  out  1  vertical sync.
- video_on  out  1  visible-region flag.
- line_start  out  1  one-clk strobe when pixel_x wraps to 0.
- frame_start  out  1  one-clk strobe when pixel_x=0 and pixel_y=0.
- change_command  out  1  one-clk redraw pulse to the handler.
- cmd_pending  out  1  a request is latched and not yet issued.

Behaviour:
- Clock and reset: single clock domain clk. Reset rst_n is asynchronous and active-low.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024.
- Reset values (held while rst_n=0):
  - Tick divider, pixel_x and pixel_y = 0.
  - h_sync and v_sync = ~SYNC_POL (inactive level).
  - video_on, pixel_tick, line_start, frame_start, change_command and cmd_pending = 0.
- Tick divider:
  - Counts 0..PIX_DIV-1; pixel_tick=1 in the clk where the count equals PIX_DIV-1.
  - PIX_DIV=1 gives pixel_tick constantly 1 after reset release.
- Counters: advance only on pixel_tick.
  - pixel_x increments; at H_TOTAL-1 it wraps to 0 and pixel_y increments.
  - pixel_y wraps to 0 from V_TOTAL-1 when pixel_x also wraps.
- Decoded outputs: all registered and aligned with the pixel_x/pixel_y values they describe. Each updates in the same clk edge as the counters.
  - h_sync = SYNC_POL when H_ACTIVE+H_FP ≤ pixel_x < H_ACTIVE+H_FP+H_SYNC.
  - v_sync: same form with the vertical parameters.
  - video_on = pixel_x<H_ACTIVE && pixel_y<V_ACTIVE. It stays 0 until the first pixel_tick after reset release.
  - line_start and frame_start: one clk wide, issued on the pixel_tick that produces the wrap.
- Command state machine (2 states):
  - IDLE: cmd_req=1 → PEND; cmd_pending=1.
  - PEND, at the vblank edge (the pixel_tick making pixel_y=V_ACTIVE, pixel_x=0):
    - change_busy=0 → change_command=1 for exactly one clk, cmd_pending=0, return to IDLE.
    - change_busy=1 → stay PEND; retry at the next frame's vblank edge.
  - cmd_req asserted in the same clk as the vblank edge while IDLE: issue change_command on that edge (request folds into the issue).
  - cmd_req held high, or re-pulsed while PEND: no extra effect. Requests coalesce; at most one change_command per frame.
  - cmd_req still high in the clk after an issue: re-enters PEND for the next frame.
- Reset mid-operation: counters, divider and command state clear immediately. A pending request is discarded.
- Arithmetic: 10-bit unsigned compares. No negative intermediates.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480 timing constants;
  - H_TOTAL/V_TOTAL derivation functions;
  - the IDLE/PEND state encoding;
  - the sync polarity constant.
- One sub-module, vga_pixel_tick: the PIX_DIV divider, with clk, rst_n and pixel_tick ports.
- Counters, decode and command FSM remain in the top.

Test Plan:
- Reset/PIX_DIV=1: hold rst_n=0 for 5 clk → all outputs at reset values, h_sync=v_sync=1. Release → pixel_x steps 0,1,2… each clk.
- Horizontal line: h_sync=0 exactly for pixel_x 656..751 (96 ticks); video_on=0 for pixel_x≥640; line_start once per 800 ticks.
- Vertical frame: v_sync=0 only on lines 490..491; frame_start once per 420000 ticks; pixel_y wraps 524→0 with pixel_x 799→0.
- Command timing: pulse cmd_req at pixel_y=100 → cmd_pending=1; change_command single clk at pixel_y=480, pixel_x=0; cmd_pending=0 after.
- Busy deferral: request pending, change_busy=1 over the first vblank edge → no pulse. Busy low next frame → one pulse at that frame's line 480.
- PIX_DIV=2 plus mid-frame reset: pixel_tick every 2nd clk, counters advance half-rate. Assert rst_n=0 at pixel_y=300 with a request pending → counters 0, cmd_pending=0, and no change_command afterwards without a new cmd_req.
